// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 command scheduler.
//   PS2_ACK / PS2_RESEND / PS2_BAT_OK : device response bytes
//   sched_state_t                     : scheduler FSM states
//   ack_timeout_cycles()              : converts the ACK timeout from us to clk cycles
package ps2_pkg;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } sched_state_t;

  function automatic int ack_timeout_cycles(input int timeout_us, input int clk_per_ns);
    return (timeout_us * 1000) / clk_per_ns;
  endfunction

endpackage

// File: rtl/ps2_cmd_sched_if.sv
// ps2_cmd_sched_if: bundles the requester, host-controller tx/rx and key-consumer
// channels of the PS/2 command scheduler.
//   slave  : scheduler side (drives req_ready/done/err, tx_*, rx_ready, key_*)
//   master : environment side (requesters, host controller, key consumer)
//   req_valid/req_data/req_ready : command request handshake, one lane per requester
//   req_done/req_err             : 1-cycle completion pulses per requester
//   tx_valid/tx_data/tx_ready    : byte towards the host controller
//   rx_valid/rx_data/rx_user/rx_ready : byte from the host controller (rx_user = parity error)
//   key_valid/key_data/key_user/key_ready : forwarded scan codes
interface ps2_cmd_sched_if;

  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_ready;
  logic [1:0]      req_done;
  logic [1:0]      req_err;

  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;

  logic [7:0]      rx_data;
  logic            rx_user;
  logic            rx_valid;
  logic            rx_ready;

  logic [7:0]      key_data;
  logic            key_user;
  logic            key_valid;
  logic            key_ready;

  modport slave (
    input  req_valid, req_data, tx_ready, rx_data, rx_user, rx_valid, key_ready,
    output req_ready, req_done, req_err, tx_valid, tx_data, rx_ready,
           key_data, key_user, key_valid
  );

  modport master (
    output req_valid, req_data, tx_ready, rx_data, rx_user, rx_valid, key_ready,
    input  req_ready, req_done, req_err, tx_valid, tx_data, rx_ready,
           key_data, key_user, key_valid
  );

endinterface

// File: rtl/ps2_rr_arbiter.sv
// ps2_rr_arbiter: 2-way round-robin grant.
//   clk, reset : system clock, synchronous active-high reset
//   en         : arbitration allowed this cycle
//   req        : request per requester
//   grant      : one-hot grant (zero when !en or no request)
//   grant_idx  : index of the granted requester
// A grant is always accepted in the same cycle (grant doubles as ready), so the
// pointer moves to favour the other requester whenever any grant is issued.
module ps2_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (!ptr_q) begin
        grant[0] = req[0];
        grant[1] = req[1] && !req[0];
      end else begin
        grant[1] = req[1];
        grant[0] = req[0] && !req[1];
      end
    end
  end

  assign grant_idx = grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (|grant) begin
      ptr_q <= ~grant_idx;
    end
  end

endmodule

// File: rtl/ps2_cmd_sched.sv
// ps2_cmd_sched: sequences host->device commands from two requesters onto one
// PS/2 host-controller tx channel, waits for the device ACK with a timeout, and
// forwards every other received byte to the key consumer.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : ps2_cmd_sched_if.slave (request, tx, rx and key channels)
// Parameters: CLK_PER (ns), ACK_TIMEOUT_US (us), MAX_RETRY (resends per command).
// Build option: PS2_CMD_RETRY_EN -- when defined, a RESEND re-issues the same
// byte up to MAX_RETRY times; otherwise a RESEND fails the command at once.
//
// state    | meaning
// IDLE     | no command in flight, arbitrating requesters
// ISSUE    | presenting the captured byte on tx
// WAIT_ACK | byte sent, waiting for ACK/RESEND/parity error or timeout
module ps2_cmd_sched
  import ps2_pkg::*;
#(
  parameter int CLK_PER        = 10,
  parameter int ACK_TIMEOUT_US = 20000,
  parameter int MAX_RETRY      = 3
) (
  input logic            clk,
  input logic            reset,
  ps2_cmd_sched_if.slave bus
);

  localparam int                TO_CYC  = ack_timeout_cycles(ACK_TIMEOUT_US, CLK_PER);
  localparam int                CNT_W   = $clog2(TO_CYC) + 1;
  localparam logic [CNT_W-1:0]  CNT_TO  = CNT_W'(TO_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             owner_q, owner_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic             key_valid_q;
  logic [7:0]       key_data_q;
  logic             key_user_q;

  logic [1:0]       grant;
  logic             grant_idx;
  logic             rsp_byte;
  logic             rsp_hit;
  logic             key_load;

`ifdef PS2_CMD_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  ps2_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        ((state_q == IDLE) && !reset),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Only while a command waits are ACK/RESEND/parity-error bytes taken as its
  // response; in any other state they are ordinary traffic for the key path.
  assign rsp_byte = (state_q == WAIT_ACK) &&
                    (bus.rx_user || (bus.rx_data == PS2_ACK) || (bus.rx_data == PS2_RESEND));
  assign rsp_hit  = rsp_byte && bus.rx_valid;
  assign key_load = bus.rx_valid && !rsp_byte && (!key_valid_q || bus.key_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    owner_d = owner_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
`ifdef PS2_CMD_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          byte_d  = bus.req_data[grant_idx];
          owner_d = grant_idx;
          state_d = ISSUE;
`ifdef PS2_CMD_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ISSUE: begin
        if (bus.tx_ready) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
        end
      end
      WAIT_ACK: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A response in the expiry cycle takes precedence over the timeout.
        if (rsp_hit) begin
          if (bus.rx_user) begin
            err_d[owner_q] = 1'b1;
            state_d        = IDLE;
          end else if (bus.rx_data == PS2_ACK) begin
            done_d[owner_q] = 1'b1;
            state_d         = IDLE;
          end else begin
`ifdef PS2_CMD_RETRY_EN
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
              err_d[owner_q] = 1'b1;
              state_d        = IDLE;
            end else begin
              retry_d = retry_q + 1'b1;
              cnt_d   = '0;
              state_d = ISSUE;
            end
`else
            err_d[owner_q] = 1'b1;
            state_d        = IDLE;
`endif
          end
        end else if (cnt_q == CNT_TO) begin
          err_d[owner_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      owner_q <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
`ifdef PS2_CMD_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PS2_CMD_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      key_data_q  <= '0;
      key_user_q  <= 1'b0;
    end else if (key_load) begin
      key_valid_q <= 1'b1;
      key_data_q  <= bus.rx_data;
      key_user_q  <= bus.rx_user;
    end else if (bus.key_ready) begin
      key_valid_q <= 1'b0;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign bus.req_ready = grant;
  assign bus.req_done  = done_q;
  assign bus.req_err   = err_q;
  assign bus.tx_valid  = (state_q == ISSUE) && !reset;
  assign bus.tx_data   = byte_q;
  assign bus.rx_ready  = !reset && (rsp_byte || !key_valid_q || bus.key_ready);
  assign bus.key_valid = key_valid_q;
  assign bus.key_data  = key_data_q;
  assign bus.key_user  = key_user_q;

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// tb_ps2_cmd_sched: self-checking bench for ps2_cmd_sched. Expected commands
// (owner, byte) are queued when requests are driven and popped when the DUT
// transmits / completes them. Timeout is shortened to 100 cycles.
module tb_ps2_cmd_sched;
  import ps2_pkg::*;

  localparam int CLK_PER = 10;
  localparam int ACK_US  = 1;
  localparam int TO      = ACK_US * 1000 / CLK_PER;

  typedef struct {
    logic       owner;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   key_cnt = 0;
  logic mdl_ptr = 1'b0;
  exp_t exp_q[$];

  ps2_cmd_sched_if bus ();

  ps2_cmd_sched #(
    .CLK_PER        (CLK_PER),
    .ACK_TIMEOUT_US (ACK_US),
    .MAX_RETRY      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #(CLK_PER / 2) clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((|bus.req_done) || (|bus.req_err)) pulse_cnt <= pulse_cnt + 1;
    if (bus.key_valid) key_cnt <= key_cnt + 1;
  end

  initial begin
    #(CLK_PER * 50000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic who, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    bus.req_data[who]  = d;
    bus.req_valid[who] = 1'b1;
    exp_q.push_back('{owner: who, data: d});
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready[who]) begin
        ok = 1'b1;
        break;
      end
      step;
    end
    if (ok) begin
      step;
      mdl_ptr = ~who;
    end
    bus.req_valid[who] = 1'b0;
  endtask

  task automatic wait_tx(output logic [7:0] d, output int acc, output bit ok);
    ok = 1'b0;
    d = '0;
    acc = 0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.tx_valid) begin
        d = bus.tx_data;
        ok = 1'b1;
        break;
      end
      step;
    end
    if (ok) begin
      step;
      acc = cyc;
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic u, output bit ok);
    ok = 1'b0;
    bus.rx_data  = d;
    bus.rx_user  = u;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.rx_ready) begin
        ok = 1'b1;
        break;
      end
      step;
    end
    if (ok) step;
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 2'b11;
    repeat (3) step;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 00", bus.req_ready);
    end
    checks++;
    if ({bus.req_done, bus.req_err, bus.tx_valid, bus.rx_ready, bus.key_valid,
         bus.key_data, bus.key_user, bus.tx_data} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: done %b err %b txv %b rxr %b keyv %b keyd %h txd %h want all 0",
               bus.req_done, bus.req_err, bus.tx_valid, bus.rx_ready, bus.key_valid,
               bus.key_data, bus.tx_data);
    end
    bus.req_valid = 2'b00;
    reset = 1'b0;
    mdl_ptr = 1'b0;
    step;
  endtask

  task automatic test_single_ack;
    bit ok;
    logic [7:0] d;
    int acc, k0;
    exp_t e;
    k0 = key_cnt;
    issue_one(1'b0, 8'hED, ok);
    checks++;
    if (!ok || bus.tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant_latency: ok %0d tx_valid %b want 1", ok, bus.tx_valid);
    end
    wait_tx(d, acc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== e.data) begin
      errors++;
      $display("FAIL single_tx_data: got %h want %h (ok %0d)", d, e.data, ok);
    end
    repeat (50) step;
    send_rx(PS2_ACK, 1'b0, ok);
    checks++;
    if (!ok || bus.req_done !== 2'b01 || bus.req_err !== 2'b00) begin
      errors++;
      $display("FAIL single_done: done %b err %b want 01/00", bus.req_done, bus.req_err);
    end
    step;
    checks++;
    if (bus.req_done !== 2'b00) begin
      errors++;
      $display("FAIL single_done_pulse_width: got %b want 00", bus.req_done);
    end
    checks++;
    if (key_cnt !== k0) begin
      errors++;
      $display("FAIL single_key_untouched: key_valid cycles %0d want 0", key_cnt - k0);
    end
  endtask

  task automatic run_pair(input logic [7:0] d0, input logic [7:0] d1);
    bit ok, got;
    logic g;
    logic [7:0] d;
    logic [1:0] oh;
    int acc;
    exp_t e;
    bus.req_data[0] = d0;
    bus.req_data[1] = d1;
    bus.req_valid = 2'b11;
    exp_q.push_back('{owner: mdl_ptr, data: (mdl_ptr ? d1 : d0)});
    exp_q.push_back('{owner: ~mdl_ptr, data: (mdl_ptr ? d0 : d1)});
    for (int k = 0; k < 2; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (|bus.req_ready) begin
          got = 1'b1;
          break;
        end
        step;
      end
      e = exp_q.pop_front();
      oh = 2'b01 << e.owner;
      checks++;
      if (!got || bus.req_ready !== oh) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %b want %b", k, bus.req_ready, oh);
      end
      g = bus.req_ready[1];
      step;
      bus.req_valid[g] = 1'b0;
      mdl_ptr = ~g;
      wait_tx(d, acc, ok);
      checks++;
      if (!ok || d !== e.data) begin
        errors++;
        $display("FAIL rr_tx_%0d: got %h want %h", k, d, e.data);
      end
      send_rx(PS2_ACK, 1'b0, ok);
      checks++;
      if (!ok || bus.req_done !== oh) begin
        errors++;
        $display("FAIL rr_done_%0d: got %b want %b", k, bus.req_done, oh);
      end
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_rr;
    bit ok;
    logic [7:0] d;
    int acc;
    exp_t e;
    reset = 1'b1;
    repeat (2) step;
    reset = 1'b0;
    mdl_ptr = 1'b0;
    exp_q.delete();
    step;
    run_pair(8'hED, 8'hF4);
    issue_one(1'b0, 8'h11, ok);
    wait_tx(d, acc, ok);
    e = exp_q.pop_front();
    send_rx(PS2_ACK, 1'b0, ok);
    checks++;
    if (d !== e.data || bus.req_done !== 2'b01) begin
      errors++;
      $display("FAIL rr_single: tx %h done %b want %h/01", d, bus.req_done, e.data);
    end
    run_pair(8'hED, 8'hF4);
  endtask

  task automatic test_timeout;
    bit ok, seen;
    logic [7:0] d;
    int acc, at;
    exp_t e;
    issue_one(1'b1, 8'hF3, ok);
    wait_tx(d, acc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== e.data) begin
      errors++;
      $display("FAIL timeout_tx: got %h want %h", d, e.data);
    end
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < TO + 20; i++) begin
      if (bus.req_err !== 2'b00 || bus.req_done !== 2'b00) begin
        seen = 1'b1;
        at = cyc;
        break;
      end
      step;
    end
    checks++;
    if (!seen || bus.req_err !== 2'b10 || bus.req_done !== 2'b00) begin
      errors++;
      $display("FAIL timeout_err: err %b done %b want 10/00 (seen %0d)", bus.req_err, bus.req_done, seen);
    end
    checks++;
    if (at - acc !== TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", at - acc, TO + 1);
    end
  endtask

  task automatic test_expiry_race;
    bit ok;
    logic [7:0] d;
    int acc, p0;
    exp_t e;
    issue_one(1'b0, 8'hED, ok);
    wait_tx(d, acc, ok);
    e = exp_q.pop_front();
    for (int i = 0; i < TO + 5; i++) begin
      if (cyc >= acc + TO) break;
      step;
    end
    send_rx(PS2_ACK, 1'b0, ok);
    p0 = pulse_cnt;
    checks++;
    if (!ok || bus.req_done !== 2'b01 || bus.req_err !== 2'b00) begin
      errors++;
      $display("FAIL expiry_response_wins: done %b err %b want 01/00", bus.req_done, bus.req_err);
    end
    repeat (3) step;
    checks++;
    if (pulse_cnt !== p0 + 1) begin
      errors++;
      $display("FAIL expiry_no_late_err: pulses %0d want %0d", pulse_cnt - p0, 1);
    end
  endtask

  task automatic test_resend;
    bit ok;
    logic [7:0] d;
    int acc;
    exp_t e;
    issue_one(1'b0, 8'hED, ok);
    e = exp_q.pop_front();
`ifdef PS2_CMD_RETRY_EN
    for (int t = 0; t < 3; t++) begin
      wait_tx(d, acc, ok);
      checks++;
      if (!ok || d !== e.data) begin
        errors++;
        $display("FAIL resend_tx_%0d: got %h want %h", t, d, e.data);
      end
      send_rx((t < 2) ? PS2_RESEND : PS2_ACK, 1'b0, ok);
      checks++;
      if (bus.req_done !== ((t < 2) ? 2'b00 : 2'b01) || bus.req_err !== 2'b00) begin
        errors++;
        $display("FAIL resend_resp_%0d: done %b err %b", t, bus.req_done, bus.req_err);
      end
    end
`else
    wait_tx(d, acc, ok);
    checks++;
    if (!ok || d !== e.data) begin
      errors++;
      $display("FAIL resend_tx: got %h want %h", d, e.data);
    end
    send_rx(PS2_RESEND, 1'b0, ok);
    checks++;
    if (!ok || bus.req_err !== 2'b01 || bus.req_done !== 2'b00) begin
      errors++;
      $display("FAIL resend_err: err %b done %b want 01/00", bus.req_err, bus.req_done);
    end
    step;
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL resend_no_reissue: tx_valid %b want 0", bus.tx_valid);
    end
`endif
  endtask

  task automatic test_key_path;
    bit ok;
    logic [7:0] d;
    int acc;
    exp_t e;
    bus.key_ready = 1'b0;
    issue_one(1'b1, 8'hF4, ok);
    wait_tx(d, acc, ok);
    e = exp_q.pop_front();
    send_rx(8'h1C, 1'b0, ok);
    checks++;
    if (!ok || bus.key_valid !== 1'b1 || bus.key_data !== 8'h1C || bus.key_user !== 1'b0) begin
      errors++;
      $display("FAIL key_load: valid %b data %h user %b want 1/1c/0", bus.key_valid, bus.key_data, bus.key_user);
    end
    bus.rx_data = 8'h55;
    bus.rx_user = 1'b0;
    bus.rx_valid = 1'b1;
    repeat (3) step;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.key_data !== 8'h1C) begin
      errors++;
      $display("FAIL key_stall: rx_ready %b key_data %h want 0/1c", bus.rx_ready, bus.key_data);
    end
    bus.rx_valid = 1'b0;
    send_rx(PS2_ACK, 1'b0, ok);
    checks++;
    if (!ok || bus.req_done !== 2'b10 || bus.key_data !== 8'h1C) begin
      errors++;
      $display("FAIL key_ack_passes: done %b key_data %h ok %0d want 10/1c/1", bus.req_done, bus.key_data, ok);
    end
    bus.key_ready = 1'b1;
    step;
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_drain: key_valid %b want 0", bus.key_valid);
    end
    bus.key_ready = 1'b0;
    send_rx(PS2_ACK, 1'b1, ok);
    checks++;
    if (!ok || bus.key_valid !== 1'b1 || bus.key_data !== 8'hFA || bus.key_user !== 1'b1 ||
        bus.req_err !== 2'b00) begin
      errors++;
      $display("FAIL key_idle_forward: valid %b data %h user %b err %b want 1/fa/1/00",
               bus.key_valid, bus.key_data, bus.key_user, bus.req_err);
    end
    bus.key_ready = 1'b1;
    step;
    bus.key_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [7:0] d;
    int acc, p0;
    exp_t e;
    bus.key_ready = 1'b0;
    issue_one(1'b1, 8'h12, ok);
    wait_tx(d, acc, ok);
    send_rx(8'h33, 1'b0, ok);
    repeat (5) step;
    p0 = pulse_cnt;
    reset = 1'b1;
    step;
    checks++;
    if ({bus.req_ready, bus.req_done, bus.req_err, bus.tx_valid, bus.rx_ready,
         bus.key_valid, bus.key_data, bus.key_user, bus.tx_data} !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy %b done %b err %b txv %b rxr %b keyv %b keyd %h want all 0",
               bus.req_ready, bus.req_done, bus.req_err, bus.tx_valid, bus.rx_ready,
               bus.key_valid, bus.key_data);
    end
    step;
    reset = 1'b0;
    exp_q.delete();
    mdl_ptr = 1'b0;
    repeat (3) step;
    checks++;
    if (pulse_cnt !== p0 || bus.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_pulse: pulses %0d key_valid %b want 0/0", pulse_cnt - p0, bus.key_valid);
    end
    issue_one(1'b0, 8'hED, ok);
    wait_tx(d, acc, ok);
    e = exp_q.pop_front();
    send_rx(PS2_ACK, 1'b0, ok);
    checks++;
    if (d !== e.data || bus.req_done !== 2'b01) begin
      errors++;
      $display("FAIL midreset_recover: tx %h done %b want %h/01", d, bus.req_done, e.data);
    end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;
    bus.rx_data   = '0;
    bus.rx_user   = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.key_ready = 1'b0;
    test_reset();
    test_single_ack();
    test_rr();
    test_timeout();
    test_expiry_race();
    test_resend();
    test_key_path();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
